const_mult_arbiter: RTL and testbench
=====================================

# const_mult_arbiter

Shared constant-multiplier service for the compression transform datapath. Up to NUM_REQ requesters issue (operand, constant-select) pairs. A round-robin arbiter grants one request per cycle into a 2-stage pipelined shift-add multiplier covering the transform constant set, and results return on a single valid/ready response port tagged with the requester id. This replaces per-lane constant multiplier instances when lanes are time-multiplexed.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 25, operand/result width, two's complement
- ID_W, $clog2(NUM_REQ), response tag width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_data  in  NUM_REQ*DATA_W  operands, requester i at [i*DATA_W +: DATA_W]
- req_sel  in  NUM_REQ*4  constant selects, requester i at [i*4 +: 4]
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_data  out  DATA_W  product, mod 2^DATA_W
- rsp_id  out  ID_W  index of originating requester
- rsp_err  out  1  select code was invalid
- grant_cnt  out  NUM_REQ*16  per-requester grant counters (only with CONST_MULT_ARB_STATS_EN)

## Operation
- Select encoding: 0:x2, 1:x6, 2:x8, 3:x14, 4:x15, 5:x16, 6:x19, 7:x30, 8:x35, 9:x36, 10:x39; 11..15 invalid -> product 0, rsp_err=1.
- Products formed only by left shifts and add/subtract (e.g. 39x = 32x+8x-x, 30x = 32x-2x); no `*` operator. All intermediates truncated to DATA_W; overflow wraps silently.
- Arbiter: round-robin over req_valid starting after last granted index; reset pointer makes requester 0 highest priority. Pointer updates only on an actual accept.
- req_ready[i]=1 only for the granted i, and only when stage 1 can load. req_ready depends combinationally on req_valid and rsp_ready; requesters must not make req_valid depend on req_ready.
- Transfer on req_valid[i] & req_ready[i]. Requester holds data/sel stable while valid and not ready.
- Stage 1 registers operand, sel, id. Stage 2 registers product, err, id and drives rsp_*.
- Advance: s2 loads when !s2_valid | rsp_ready. s1 loads when !s1_valid | s2 loads. Bubbles collapse.
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, req_ready=0, both stage valids=0, pointer -> requester 0 first, grant_cnt=0.
- Reset mid-operation discards in-flight entries with no response.

## Timing
- Latency: accept at edge N gives rsp_valid high after edge N+2 (visible in cycle N+2).
- Throughput: one accept per cycle when rsp_ready=1.
- Backpressure: while rsp_valid & !rsp_ready, rsp_* stay stable. At most one further request is accepted (into stage 1), then req_ready=0 for all requesters.
- Simultaneous s2 consume and new accept in the same cycle is allowed and loses no data.

## Configuration
- CONST_MULT_ARB_STATS_EN defined: grant_cnt port exists. Counter i increments on each accept from requester i and saturates at 0xFFFF. Cleared by rst.
- Undefined: grant_cnt port and counters are absent. All other behaviour is identical.

## Structure
- Package const_mult_pkg holds the SEL_* localparams (codes 0..10), SEL_W=4, and the default DATA_W=25.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector and enable, outputs one-hot grant; holds the pointer register internally.
- The shift-add product is a combinational case in stage 2 input logic. No further sub-modules.

## Test plan
- req0 data=3, sel=10, rsp_ready=1 -> rsp_data=117, rsp_id=0, rsp_err=0, two cycles after accept.
- All four req_valid held high, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; one rsp per cycle.
- Continuous stream, rsp_ready low for 5 cycles -> rsp_* stable, exactly one extra accept then all req_ready=0; every result is delivered afterwards in order with no loss or duplication.
- data=0x1FFFFFF, sel=7 -> rsp_data=0x1FFFFE2 (-30); data=0x0FFFFFF, sel=5 -> 0x1FFFFF0 (wrap).
- sel=12, data=5 -> rsp_data=0, rsp_err=1; following sel=0, data=5 -> 10, rsp_err=0.
- Assert rst with both stages full -> rsp_valid=0 immediately. After release, requesters 2 and 0 both valid -> requester 0 granted first.

Source files
------------

// File: rtl/const_mult_pkg.sv
// Shared constants for the constant-multiplier service: select codes and default widths.
package const_mult_pkg;

    localparam int DATA_W = 25;
    localparam int SEL_W  = 4;

    localparam logic [SEL_W-1:0] SEL_X2  = 4'd0;
    localparam logic [SEL_W-1:0] SEL_X6  = 4'd1;
    localparam logic [SEL_W-1:0] SEL_X8  = 4'd2;
    localparam logic [SEL_W-1:0] SEL_X14 = 4'd3;
    localparam logic [SEL_W-1:0] SEL_X15 = 4'd4;
    localparam logic [SEL_W-1:0] SEL_X16 = 4'd5;
    localparam logic [SEL_W-1:0] SEL_X19 = 4'd6;
    localparam logic [SEL_W-1:0] SEL_X30 = 4'd7;
    localparam logic [SEL_W-1:0] SEL_X35 = 4'd8;
    localparam logic [SEL_W-1:0] SEL_X36 = 4'd9;
    localparam logic [SEL_W-1:0] SEL_X39 = 4'd10;

endpackage

// File: rtl/const_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searching from the index after the last accepted one.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] r_last;
    logic [ID_W-1:0] w_idx;
    logic            w_found;

    always_comb begin
        o_grant = '0;
        w_idx   = r_last;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && i_req[(int'(r_last) + k) % NUM_REQ]) begin
                w_found                              = 1'b1;
                o_grant[(int'(r_last) + k) % NUM_REQ] = 1'b1;
                w_idx                                = ID_W'((int'(r_last) + k) % NUM_REQ);
            end
        end
    end

    // Reset to the last index so requester 0 is searched first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_last <= ID_W'(NUM_REQ - 1);
        else if (i_en && w_found)
            r_last <= w_idx;
    end

endmodule

// File: rtl/const_mult_arbiter.sv
// Arbitrated 2-stage shift-add constant multiplier with tagged valid/ready response.
// Optional per-requester grant counters: define CONST_MULT_ARB_STATS_EN.
module const_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = const_mult_pkg::DATA_W,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [NUM_REQ-1:0]                    i_req_valid,
    output logic [NUM_REQ-1:0]                    o_req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]             i_req_data,
    input  logic [NUM_REQ*const_mult_pkg::SEL_W-1:0] i_req_sel,
`ifdef CONST_MULT_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]                 o_grant_cnt,
`endif
    output logic                                  o_rsp_valid,
    input  logic                                  i_rsp_ready,
    output logic [DATA_W-1:0]                     o_rsp_data,
    output logic [ID_W-1:0]                       o_rsp_id,
    output logic                                  o_rsp_err
);

    import const_mult_pkg::*;

    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_req_acc;
    logic               w_s1_load;
    logic               w_s2_load;
    logic               w_accept;
    logic [DATA_W-1:0]  w_in_data;
    logic [SEL_W-1:0]   w_in_sel;
    logic [ID_W-1:0]    w_in_id;
    logic [DATA_W-1:0]  w_prod;
    logic               w_err;

    logic               r_s1_valid;
    logic [DATA_W-1:0]  r_s1_data;
    logic [SEL_W-1:0]   r_s1_sel;
    logic [ID_W-1:0]    r_s1_id;
    logic               r_s2_valid;
    logic [DATA_W-1:0]  r_s2_data;
    logic               r_s2_err;
    logic [ID_W-1:0]    r_s2_id;

    assign w_s2_load   = !r_s2_valid || i_rsp_ready;
    assign w_s1_load   = !r_s1_valid || w_s2_load;
    assign o_req_ready = w_grant & {NUM_REQ{w_s1_load && !i_rst}};
    assign w_req_acc   = i_req_valid & o_req_ready;
    assign w_accept    = |w_req_acc;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req_valid),
        .i_en    (w_s1_load && !i_rst),
        .o_grant (w_grant)
    );

    always_comb begin
        w_in_data = '0;
        w_in_sel  = '0;
        w_in_id   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_in_data = i_req_data[i*DATA_W +: DATA_W];
                w_in_sel  = i_req_sel[i*SEL_W +: SEL_W];
                w_in_id   = ID_W'(i);
            end
        end
    end

    // All terms are DATA_W wide, so every shift and sum wraps mod 2^DATA_W.
    always_comb begin
        w_prod = '0;
        w_err  = 1'b0;
        case (r_s1_sel)
            SEL_X2:  w_prod = r_s1_data << 1;
            SEL_X6:  w_prod = (r_s1_data << 2) + (r_s1_data << 1);
            SEL_X8:  w_prod = r_s1_data << 3;
            SEL_X14: w_prod = (r_s1_data << 4) - (r_s1_data << 1);
            SEL_X15: w_prod = (r_s1_data << 4) - r_s1_data;
            SEL_X16: w_prod = r_s1_data << 4;
            SEL_X19: w_prod = (r_s1_data << 4) + (r_s1_data << 1) + r_s1_data;
            SEL_X30: w_prod = (r_s1_data << 5) - (r_s1_data << 1);
            SEL_X35: w_prod = (r_s1_data << 5) + (r_s1_data << 1) + r_s1_data;
            SEL_X36: w_prod = (r_s1_data << 5) + (r_s1_data << 2);
            SEL_X39: w_prod = (r_s1_data << 5) + (r_s1_data << 3) - r_s1_data;
            default: w_err  = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_sel   <= '0;
            r_s1_id    <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_in_data;
                r_s1_sel  <= w_in_sel;
                r_s1_id   <= w_in_id;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_err   <= 1'b0;
            r_s2_id    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_prod;
                r_s2_err  <= w_err;
                r_s2_id   <= r_s1_id;
            end
        end
    end

    assign o_rsp_valid = r_s2_valid;
    assign o_rsp_data  = r_s2_data;
    assign o_rsp_id    = r_s2_id;
    assign o_rsp_err   = r_s2_err;

`ifdef CONST_MULT_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] r_cnt;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                r_cnt <= '0;
            else if (w_req_acc[g] && r_cnt != 16'hFFFF)
                r_cnt <= r_cnt + 16'd1;
        end
        assign o_grant_cnt[g*16 +: 16] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_const_mult_arbiter.sv
// Directed, table-driven bench for const_mult_arbiter (NUM_REQ=4, DATA_W=25).
module tb_const_mult_arbiter;

    localparam int NR = 4;
    localparam int DW = 25;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_data;
    logic [NR*4-1:0]  req_sel;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [DW-1:0]    rsp_data;
    logic [IW-1:0]    rsp_id;
    logic             rsp_err;
`ifdef CONST_MULT_ARB_STATS_EN
    logic [NR*16-1:0] grant_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    const_mult_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_data  (req_data),
        .i_req_sel   (req_sel),
`ifdef CONST_MULT_ARB_STATS_EN
        .o_grant_cnt (grant_cnt),
`endif
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_id    (rsp_id),
        .o_rsp_err   (rsp_err)
    );

    typedef struct {
        int          id;
        logic [24:0] data;
        logic [3:0]  sel;
        logic [24:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_all_streams(input logic [3:0] sel, input int base);
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = DW'(base * (i + 1));
            req_sel[i*4 +: 4]    = sel;
        end
    endtask

    initial begin
        int exp_ids[6];
        int n_rsp;
        logic [3:0] exp_rdy;

        vecs[0]  = '{0, 25'd3,        4'd10, 25'd117,      1'b0};
        vecs[1]  = '{1, 25'h1FFFFFF,  4'd7,  25'h1FFFFE2,  1'b0};
        vecs[2]  = '{2, 25'h0FFFFFF,  4'd5,  25'h1FFFFF0,  1'b0};
        vecs[3]  = '{3, 25'd5,        4'd12, 25'd0,        1'b1};
        vecs[4]  = '{3, 25'd5,        4'd0,  25'd10,       1'b0};
        vecs[5]  = '{0, 25'd7,        4'd1,  25'd42,       1'b0};
        vecs[6]  = '{1, 25'd7,        4'd2,  25'd56,       1'b0};
        vecs[7]  = '{2, 25'd7,        4'd3,  25'd98,       1'b0};
        vecs[8]  = '{3, 25'd7,        4'd4,  25'd105,      1'b0};
        vecs[9]  = '{0, 25'd7,        4'd6,  25'd133,      1'b0};
        vecs[10] = '{1, 25'd7,        4'd8,  25'd245,      1'b0};
        vecs[11] = '{2, 25'd7,        4'd9,  25'd252,      1'b0};
        vecs[12] = '{0, 25'h1FFFFFF,  4'd10, 25'h1FFFFD9,  1'b0};
        vecs[13] = '{1, 25'd1,        4'd15, 25'd0,        1'b1};

        req_valid = '0;
        req_data  = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        #2;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data), 32'd0);
        chk("reset_rsp_id", 32'(rsp_id), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        do_reset();

        // Single requests: accept, nothing after one edge, result after two.
        foreach (vecs[v]) begin
            req_data                    = '0;
            req_data[vecs[v].id*DW +: DW] = vecs[v].data;
            req_sel[vecs[v].id*4 +: 4]  = vecs[v].sel;
            req_valid                   = 4'(1 << vecs[v].id);
            #1;
            chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
            tick();
            req_valid = '0;
            #1;
            chk($sformatf("vec%0d_lat1_valid", v), 32'(rsp_valid), 32'd0);
            tick();
            chk($sformatf("vec%0d_valid", v), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d_data", v), 32'(rsp_data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_err", v), 32'(rsp_err), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_id", v), 32'(rsp_id), 32'(vecs[v].id));
        end
        tick();

        // Round robin with all requesters asserted and no backpressure.
        do_reset();
        set_all_streams(4'd0, 1);
        req_valid = 4'hF;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr_ready_c%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            if (c >= 2) begin
                chk($sformatf("rr_rsp_valid_c%0d", c), 32'(rsp_valid), 32'd1);
                chk($sformatf("rr_rsp_id_c%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
                chk($sformatf("rr_rsp_data_c%0d", c), 32'(rsp_data), 32'(2 * ((c - 2) % 4 + 1)));
            end
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        // Backpressure: rsp_ready low in cycles 1..5 of a continuous stream.
        do_reset();
        set_all_streams(4'd0, 10);
        exp_ids = '{0, 1, 2, 3, 0, 1};
        n_rsp   = 0;
        for (int c = 0; c < 26; c++) begin
            req_valid = (c < 10) ? 4'hF : 4'h0;
            rsp_ready = !(c >= 1 && c <= 5);
            #1;
            case (c)
                0, 8:    exp_rdy = 4'b0001;
                1, 9:    exp_rdy = 4'b0010;
                6:       exp_rdy = 4'b0100;
                7:       exp_rdy = 4'b1000;
                default: exp_rdy = 4'b0000;
            endcase
            chk($sformatf("bp_ready_c%0d", c), 32'(req_ready), 32'(exp_rdy));
            if (c >= 2 && c <= 5) begin
                chk($sformatf("bp_hold_valid_c%0d", c), 32'(rsp_valid), 32'd1);
                chk($sformatf("bp_hold_id_c%0d", c), 32'(rsp_id), 32'd0);
                chk($sformatf("bp_hold_data_c%0d", c), 32'(rsp_data), 32'd20);
            end
            if (rsp_valid && rsp_ready) begin
                if (n_rsp < 6) begin
                    chk($sformatf("bp_rsp%0d_id", n_rsp), 32'(rsp_id), 32'(exp_ids[n_rsp]));
                    chk($sformatf("bp_rsp%0d_data", n_rsp), 32'(rsp_data), 32'(20 * (exp_ids[n_rsp] + 1)));
                end
                n_rsp++;
            end
            tick();
        end
        chk("bp_rsp_count", 32'(n_rsp), 32'd6);

        // Reset with both stages full discards everything; pointer restarts at 0.
        do_reset();
        rsp_ready = 1'b0;
        req_data  = '0;
        req_sel   = '0;
        req_data[0 +: DW] = 25'd9;
        req_valid = 4'b0001;
        tick();
        tick();
        req_valid = '0;
        #1;
        chk("rstmid_full_valid", 32'(rsp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_valid_now", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        req_data[2*DW +: DW] = 25'd4;
        req_valid = 4'b0101;
        #1;
        chk("rstmid_no_stale", 32'(rsp_valid), 32'd0);
        chk("rstmid_grant0", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0100;
        #1;
        chk("rstmid_no_stale2", 32'(rsp_valid), 32'd0);
        chk("rstmid_grant2", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("rstmid_first_id", 32'(rsp_id), 32'd0);
        chk("rstmid_first_data", 32'(rsp_data), 32'd18);
        tick();
        chk("rstmid_second_id", 32'(rsp_id), 32'd2);
        chk("rstmid_second_data", 32'(rsp_data), 32'd8);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
